// File: rtl/debounce_sync_pkg.sv
// Shared definitions for the debounce_sync block: FSM state encodings,
// default parameter values and the stability-counter width helper.
package debounce_sync_pkg;

    // Encoding order is fixed so the state register reads the same in every dump
    typedef enum logic [1:0] {
        ST_STABLE_LOW  = 2'd0,
        ST_CHECK_HIGH  = 2'd1,
        ST_STABLE_HIGH = 2'd2,
        ST_CHECK_LOW   = 2'd3
    } state_t;

    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 10;

    // Counter width is clog2 of the cycle count, but never narrower than one bit
    function automatic int counter_width(input int cycles);
        return (cycles <= 1) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/debounce_sync_sync_chain.sv
// Multi-flop synchronizer that brings an asynchronous level into the clk
// domain. The output is the last flop of the chain.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_sync
);

    logic [STAGES-1:0] stages;

    // Shift the raw input through the chain; every flop clears on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stages <= '0;
        end else begin
            stages <= {stages[STAGES-2:0], i_async};
        end
    end

    assign o_sync = stages[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Debounces one asynchronous, bouncy input into a clean synchronous level
// with single-cycle rise/fall pulses. A synchronizer chain feeds a 4-state
// FSM that only accepts a new level after it has been seen on
// DEBOUNCE_CYCLES+1 consecutive synchronized samples.
module debounce_sync
    import debounce_sync_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_clean,
    output logic o_clean_b,
    output logic o_rise,
    output logic o_fall,
    output logic o_busy
);

    localparam int               CNT_W    = counter_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s;
    state_t           state;
    logic [CNT_W-1:0] count;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync_chain (
        .clk     (clk),
        .reset   (reset),
        .i_async (i_raw),
        .o_sync  (s)
    );

    // Debounce FSM: a CHECK state counts matching samples, any reversal falls
    // back to the stable state with the counter cleared, and all outputs are
    // registered so they move on the same edge as the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_STABLE_LOW;
            count     <= '0;
            o_clean   <= 1'b0;
            o_clean_b <= 1'b1;
            o_rise    <= 1'b0;
            o_fall    <= 1'b0;
            o_busy    <= 1'b0;
        end else begin
            o_rise <= 1'b0;
            o_fall <= 1'b0;
            case (state)
                ST_STABLE_LOW: begin
                    if (s) begin
                        state  <= ST_CHECK_HIGH;
                        count  <= '0;
                        o_busy <= 1'b1;
                    end
                end
                ST_CHECK_HIGH: begin
                    if (!s) begin
                        state  <= ST_STABLE_LOW;
                        count  <= '0;
                        o_busy <= 1'b0;
                    end else if (count == CNT_LAST) begin
                        state     <= ST_STABLE_HIGH;
                        count     <= '0;
                        o_clean   <= 1'b1;
                        o_clean_b <= 1'b0;
                        o_rise    <= 1'b1;
                        o_busy    <= 1'b0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                ST_STABLE_HIGH: begin
                    if (!s) begin
                        state  <= ST_CHECK_LOW;
                        count  <= '0;
                        o_busy <= 1'b1;
                    end
                end
                ST_CHECK_LOW: begin
                    if (s) begin
                        state  <= ST_STABLE_HIGH;
                        count  <= '0;
                        o_busy <= 1'b0;
                    end else if (count == CNT_LAST) begin
                        state     <= ST_STABLE_LOW;
                        count     <= '0;
                        o_clean   <= 1'b0;
                        o_clean_b <= 1'b1;
                        o_fall    <= 1'b1;
                        o_busy    <= 1'b0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    state  <= ST_STABLE_LOW;
                    count  <= '0;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync with SYNC_STAGES=2, DEBOUNCE_CYCLES=4:
// a change first sampled on edge 0 is accepted on edge 6.
module tb_debounce_sync;

    logic clk;
    logic reset;
    logic i_raw;
    logic o_clean;
    logic o_clean_b;
    logic o_rise;
    logic o_fall;
    logic o_busy;

    logic [4:0] outs;

    int num_checks;
    int num_errors;

    debounce_sync #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_raw     (i_raw),
        .o_clean   (o_clean),
        .o_clean_b (o_clean_b),
        .o_rise    (o_rise),
        .o_fall    (o_fall),
        .o_busy    (o_busy)
    );

    assign outs = {o_clean, o_clean_b, o_rise, o_fall, o_busy};

    // 10-time-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected output vector {clean, clean_b, rise, fall, busy}
    function automatic logic [4:0] exp_vec(input bit clean, input bit rise,
                                           input bit fall, input bit busy);
        return {clean, ~clean, rise, fall, busy};
    endfunction

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one raw sample and let one rising edge capture it
    task automatic applyStimulus(input logic raw);
        i_raw = raw;
        tick();
    endtask

    // Compare {clean, clean_b, rise, fall, busy} against the expected vector
    task automatic checkOutput(input string tag, input logic [4:0] observed,
                               input logic [4:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got %b expected %b (clean,clean_b,rise,fall,busy)",
                     tag, observed, expected);
        end
    endtask

    // Directed scenarios in sequence
    initial begin
        num_checks = 0;
        num_errors = 0;
        reset      = 1'b1;
        i_raw      = 1'b1;

        // Reset held with the input already high
        #3;
        checkOutput("reset immediate", outs, exp_vec(0, 0, 0, 0));
        repeat (3) tick();
        checkOutput("reset held", outs, exp_vec(0, 0, 0, 0));
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1);
            checkOutput($sformatf("post-reset e%0d", k), outs,
                        exp_vec(k >= 6, k == 6, 0, (k >= 2) && (k <= 5)));
        end

        // Falling edge from a clean high level
        for (int k = 0; k < 9; k++) begin
            applyStimulus(1'b0);
            checkOutput($sformatf("fall e%0d", k), outs,
                        exp_vec(k < 6, 0, k == 6, (k >= 2) && (k <= 5)));
        end

        // Four-cycle glitch is rejected
        for (int k = 0; k < 10; k++) begin
            applyStimulus(k < 4);
            checkOutput($sformatf("glitch e%0d", k), outs,
                        exp_vec(0, 0, 0, (k >= 2) && (k <= 5)));
        end

        // Five-cycle pulse is exactly enough; the following low is accepted too
        for (int k = 0; k < 13; k++) begin
            applyStimulus(k < 5);
            checkOutput($sformatf("threshold e%0d", k), outs,
                        exp_vec((k >= 6) && (k <= 10), k == 6, k == 11,
                                ((k >= 2) && (k <= 5)) || ((k >= 7) && (k <= 10))));
        end

        // Bounce 1,0,1,0,1 then hold high; final 0->1 sampled on edge 4
        for (int k = 0; k < 12; k++) begin
            applyStimulus((k < 5) ? ((k % 2) == 0) : 1'b1);
            checkOutput($sformatf("bounce e%0d", k), outs,
                        exp_vec(k >= 10, k == 10, 0,
                                (k == 2) || (k == 4) || ((k >= 6) && (k <= 9))));
        end

        // Return to a settled low level
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0);
        end
        checkOutput("settle low", outs, exp_vec(0, 0, 0, 0));

        // Reset asserted while qualifying a high level with counter at 2
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1);
        end
        checkOutput("mid-check busy", outs, exp_vec(0, 0, 0, 1));
        #1;
        reset = 1'b1;
        #1;
        checkOutput("mid-check async reset", outs, exp_vec(0, 0, 0, 0));
        repeat (2) tick();
        checkOutput("mid-check reset held", outs, exp_vec(0, 0, 0, 0));
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1);
            checkOutput($sformatf("requalify e%0d", k), outs,
                        exp_vec(k >= 6, k == 6, 0, (k >= 2) && (k <= 5)));
        end

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
